// File: rtl/nv_pg_iso_seq.sv
// Per-channel power-gate sequencer with an isolation clamp on the data boundary.
// Each channel steps a thermometer of switch enables, handshakes on pwr_ack and gates isolation.
module nv_pg_iso_seq #(
  parameter int DW       = 32,
  parameter int NCH      = 4,
  parameter int NSTAGE   = 4,
  parameter int STEP_CYC = 8,
  parameter int ACK_TO   = 256
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rst,
  input  logic [NCH-1:0]        pg_req,
  input  logic [NCH-1:0]        pwr_ack,
  input  logic [NCH*DW-1:0]     data_in,
  output logic [NCH*DW-1:0]     data_out,
  output logic [NCH-1:0]        iso_en,
  output logic [NCH*NSTAGE-1:0] pwr_en,
  output logic [NCH-1:0]        pg_off,
  output logic [NCH-1:0]        pg_busy,
  output logic [NCH-1:0]        pg_err
);

  localparam int CW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam int TW = $clog2(ACK_TO + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STEP_CYC - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(ACK_TO);
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TO - 1);

  typedef enum logic [2:0] {
    OFF,
    UP,
    UP_ACK,
    DEISO,
    ON,
    ISO,
    DOWN,
    DN_ACK
  } state_t;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_t            state;
    logic [CW-1:0]     cnt;
    logic [TW-1:0]     to_cnt;
    logic [NSTAGE-1:0] pe;
    logic              iso;
    logic              off;
    logic              busy;
    logic              err;
    logic              cnt_wrap;

    assign cnt_wrap = (cnt == CNT_MAX);

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
        state  <= OFF;
        cnt    <= '0;
        to_cnt <= '0;
        pe     <= '0;
        iso    <= 1'b1;
        off    <= 1'b1;
        busy   <= 1'b0;
        err    <= 1'b0;
      end else begin
        // cnt free-runs; each sequence start reloads it so wraps land on the step grid
        cnt <= cnt_wrap ? '0 : cnt + CW'(1);
        case (state)
          OFF: begin
            if (!pg_req[c]) begin
              state <= UP;
              pe    <= NSTAGE'(1);
              off   <= 1'b0;
              busy  <= 1'b1;
              cnt   <= '0;
            end
          end
          UP: begin
            if (cnt_wrap) begin
              if (&pe) begin
                state  <= UP_ACK;
                to_cnt <= '0;
              end else begin
                pe <= (pe << 1) | NSTAGE'(1);
              end
            end
          end
          UP_ACK: begin
            if (pwr_ack[c]) begin
              state  <= DEISO;
              cnt    <= '0;
              to_cnt <= '0;
            end else begin
              if (to_cnt != TO_MAX) to_cnt <= to_cnt + TW'(1);
              if (to_cnt == TO_LAST) err <= 1'b1;
            end
          end
          DEISO: begin
            if (cnt_wrap) begin
              state <= ON;
              iso   <= 1'b0;
              busy  <= 1'b0;
            end
          end
          ON: begin
            if (pg_req[c]) begin
              state <= ISO;
              iso   <= 1'b1;
              busy  <= 1'b1;
              cnt   <= '0;
            end
          end
          ISO: begin
            if (cnt_wrap) begin
              state <= DOWN;
              pe    <= pe >> 1;
            end
          end
          DOWN: begin
            if (cnt_wrap) begin
              if (pe == '0) begin
                state  <= DN_ACK;
                to_cnt <= '0;
              end else begin
                pe <= pe >> 1;
              end
            end
          end
          DN_ACK: begin
            if (!pwr_ack[c]) begin
              state  <= OFF;
              off    <= 1'b1;
              busy   <= 1'b0;
              to_cnt <= '0;
            end else begin
              if (to_cnt != TO_MAX) to_cnt <= to_cnt + TW'(1);
              if (to_cnt == TO_LAST) err <= 1'b1;
            end
          end
          default: state <= OFF;
        endcase
      end
    end

    assign iso_en[c]                   = iso;
    assign pg_off[c]                   = off;
    assign pg_busy[c]                  = busy;
    assign pg_err[c]                   = err;
    assign pwr_en[c*NSTAGE +: NSTAGE]  = pe;
    assign data_out[c*DW +: DW]        = data_in[c*DW +: DW] & {DW{~iso}};
  end

endmodule

// File: tb/tb_nv_pg_iso_seq.sv
// Scoreboard bench for nv_pg_iso_seq: expected output vectors are queued per cycle from
// the documented timing, then popped and compared at each negedge.
module tb_nv_pg_iso_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pg_req;
  logic [1:0]  pwr_ack;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic [1:0]  iso_en;
  logic [7:0]  pwr_en;
  logic [1:0]  pg_off;
  logic [1:0]  pg_busy;
  logic [1:0]  pg_err;
  logic [31:0] obs;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb_q[$];

  typedef struct packed {
    logic [3:0] pe;
    logic       iso;
    logic       off;
    logic       busy;
  } ch_t;

  always #5 clk = ~clk;

  nv_pg_iso_seq #(
    .DW(8),
    .NCH(2),
    .NSTAGE(4),
    .STEP_CYC(4),
    .ACK_TO(16)
  ) dut (
    .nvdla_core_clk(clk),
    .nvdla_core_rst(rst),
    .pg_req(pg_req),
    .pwr_ack(pwr_ack),
    .data_in(data_in),
    .data_out(data_out),
    .iso_en(iso_en),
    .pwr_en(pwr_en),
    .pg_off(pg_off),
    .pg_busy(pg_busy),
    .pg_err(pg_err)
  );

  assign obs = {pwr_en, iso_en, pg_off, pg_busy, pg_err, data_out};

  function automatic logic [3:0] therm(int ones);
    logic [4:0] t;
    t = 5'((1 << ones) - 1);
    return t[3:0];
  endfunction

  function automatic ch_t ch_off();
    return {4'h0, 1'b1, 1'b1, 1'b0};
  endfunction

  function automatic ch_t ch_on();
    return {4'hF, 1'b0, 1'b0, 1'b0};
  endfunction

  // k = cycles after the sampling edge; ack_at = edge at which UP_ACK sees the ack
  function automatic ch_t ch_up(int k, int ack_at);
    int   ones;
    logic act;
    ones = k / 4 + 1;
    if (ones > 4) ones = 4;
    act = (k < ack_at + 4);
    return {therm(ones), act, 1'b0, act};
  endfunction

  function automatic ch_t ch_down(int k);
    int   cl;
    logic done;
    cl = k / 4;
    if (cl > 4) cl = 4;
    done = (k >= 21);
    return {therm(4 - cl), 1'b1, done, ~done};
  endfunction

  function automatic logic [31:0] vec(ch_t c0, ch_t c1, logic [1:0] err, logic [15:0] din);
    logic [15:0] d;
    d = din & {{8{~c1.iso}}, {8{~c0.iso}}};
    return {c1.pe, c0.pe, c1.iso, c0.iso, c1.off, c0.off, c1.busy, c0.busy, err, d};
  endfunction

  task automatic test_reset();
    logic [31:0] e;
    rst     = 1'b0;
    pg_req  = 2'b11;
    pwr_ack = 2'b00;
    data_in = 16'hA5A5;
    #2 rst = 1'b1;
    #1;
    sb_q.push_back(vec(ch_off(), ch_off(), 2'b00, data_in));
    e = sb_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_async actual=%h required=%h", obs, e);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) sb_q.push_back(vec(ch_off(), ch_off(), 2'b00, data_in));
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_hold k=%0d actual=%h required=%h", k, obs, e);
      end
    end
  endtask

  task automatic test_power_up();
    logic [31:0] e;
    pg_req[0]  = 1'b0;
    pwr_ack[0] = 1'b1;
    for (int k = 0; k < 26; k++) sb_q.push_back(vec(ch_up(k, 17), ch_off(), 2'b00, data_in));
    for (int k = 0; k < 26; k++) begin
      @(posedge clk);
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL power_up k=%0d actual=%h required=%h", k, obs, e);
      end
    end
  endtask

  task automatic test_power_down();
    logic [31:0] e;
    pg_req[0] = 1'b1;
    for (int k = 0; k < 26; k++) sb_q.push_back(vec(ch_down(k), ch_off(), 2'b00, data_in));
    for (int k = 0; k < 26; k++) begin
      @(posedge clk);
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL power_down k=%0d actual=%h required=%h", k, obs, e);
      end
      pwr_ack[0] = pwr_en[3];
    end
  endtask

  task automatic test_timeout();
    logic [31:0] e;
    data_in    = 16'h5AC3;
    pg_req[1]  = 1'b0;
    pwr_ack[1] = 1'b0;
    for (int k = 0; k < 48; k++)
      sb_q.push_back(vec(ch_off(), ch_up(k, 40), (k >= 32) ? 2'b10 : 2'b00, data_in));
    for (int k = 0; k < 48; k++) begin
      @(posedge clk);
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL ack_timeout k=%0d actual=%h required=%h", k, obs, e);
      end
      if (k == 39) pwr_ack[1] = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    pg_req[1] = 1'b1;
    for (int k = 0; k < 48; k++)
      sb_q.push_back(vec(ch_off(), (k < 22) ? ch_down(k) : ch_up(k - 22, 17), 2'b10, data_in));
    for (int k = 0; k < 48; k++) begin
      @(posedge clk);
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL back_to_back k=%0d actual=%h required=%h", k, obs, e);
      end
      pwr_ack[1] = pwr_en[7];
      if (k == 1) pg_req[1] = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    pg_req[0] = 1'b0;
    for (int k = 0; k < 6; k++) sb_q.push_back(vec(ch_up(k, 17), ch_on(), 2'b10, data_in));
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL pre_reset k=%0d actual=%h required=%h", k, obs, e);
      end
      pwr_ack[0] = pwr_en[3];
    end
    @(posedge clk);
    #2;
    rst       = 1'b1;
    pg_req[1] = 1'b1;
    pwr_ack   = 2'b00;
    #1;
    sb_q.push_back(vec(ch_off(), ch_off(), 2'b00, data_in));
    sb_q.push_back(vec(ch_off(), ch_off(), 2'b00, data_in));
    e = sb_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL mid_reset_async actual=%h required=%h", obs, e);
    end
    @(negedge clk);
    e = sb_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL mid_reset_hold actual=%h required=%h", obs, e);
    end
    rst = 1'b0;
    for (int k = 0; k < 26; k++) sb_q.push_back(vec(ch_up(k, 17), ch_off(), 2'b00, data_in));
    for (int k = 0; k < 26; k++) begin
      @(posedge clk);
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL resume_up k=%0d actual=%h required=%h", k, obs, e);
      end
      pwr_ack[0] = pwr_en[3];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_power_up();
    test_power_down();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
